instr_aligner: RTL

Fetch-side realigner between instruction memory and the RVC decompressor. Issues word-aligned fetches, buffers returned 32-bit words as halfwords, and presents one complete instruction per handshake: a 16-bit compressed instruction (low two bits != 2'b11) or a 32-bit instruction, which may straddle two fetched words. It tracks the instruction PC and handles redirects to any halfword-aligned target.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/instr_hw_buf.sv | 77 +++++++
 rtl/instr_aligner.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch-side instruction realigner.
package rv_pkg;

    localparam int HW_W   = 16;
    localparam int INST_W = 32;

    // Low two bits of a halfword that mark the start of a 32-bit instruction.
    localparam logic [1:0] RVC_LOW_32BIT = 2'b11;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    function automatic logic hw_is_c(input logic [HW_W-1:0] hw);
        return hw[1:0] != RVC_LOW_32BIT;
    endfunction

endpackage

// File: rtl/instr_hw_buf.sv
// Three-slot halfword shift buffer: pop 1 or 2 from the head, append 1 or 2
// after whatever remains, flush empties it. Slot 0 is always the oldest.
module instr_hw_buf
    import rv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              pop_i,
    input  logic              pop_two_i,
    input  logic              push_i,
    input  logic              push_one_i,
    input  logic [INST_W-1:0] push_data_i,
    output logic [HW_W-1:0]   hw0_o,
    output logic [HW_W-1:0]   hw1_o,
    output logic [1:0]        count_o
);

    logic [HW_W-1:0] slot_q [3];
    logic [HW_W-1:0] slot_d [3];
    logic [1:0]      count_q;
    logic [1:0]      count_d;
    logic [1:0]      pop_n;
    logic [1:0]      push_n;
    logic [2:0]      rem_ext;

    assign pop_n   = pop_i  ? (pop_two_i  ? 2'd2 : 2'd1) : 2'd0;
    assign push_n  = push_i ? (push_one_i ? 2'd1 : 2'd2) : 2'd0;
    // Halfwords left after the pop; new data lands starting at this slot.
    assign rem_ext = {1'b0, count_q - pop_n};

    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
        logic [HW_W-1:0] shifted;
        logic            sel_low;
        logic            sel_high;

        if (gi + 2 < 3) begin : g_sh2
            assign shifted = (pop_n == 2'd2) ? slot_q[gi+2] :
                             (pop_n == 2'd1) ? slot_q[gi+1] : slot_q[gi];
        end else if (gi + 1 < 3) begin : g_sh1
            assign shifted = (pop_n == 2'd1) ? slot_q[gi+1] : slot_q[gi];
        end else begin : g_sh0
            assign shifted = slot_q[gi];
        end

        // A one-halfword push carries only the upper half of the word.
        assign sel_low  = push_i && !push_one_i && (rem_ext == 3'(gi));
        assign sel_high = push_i && (push_one_i ? (rem_ext == 3'(gi))
                                                : (rem_ext + 3'd1 == 3'(gi)));
        assign slot_d[gi] = sel_low  ? push_data_i[HW_W-1:0] :
                            sel_high ? push_data_i[INST_W-1:HW_W] : shifted;
    end

    // Occupancy after pop and push; flush wins over both.
    always_comb begin
        count_d = count_q - pop_n + push_n;
        if (flush_i) begin
            count_d = 2'd0;
        end
    end

    // Slot and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q  <= '{default: '0};
            count_q <= 2'd0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
        end
    end

    assign hw0_o   = slot_q[0];
    assign hw1_o   = slot_q[1];
    assign count_o = count_q;

endmodule

// File: rtl/instr_aligner.sv
// Fetch-side realigner: word-aligned fetches in, one whole 16/32-bit
// instruction out per handshake, with PC tracking and halfword redirects.
module instr_aligner
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              fetch_req_valid,
    output logic [31:0]       fetch_req_addr,
    input  logic              fetch_req_ready,
    input  logic              fetch_rsp_valid,
    input  logic [INST_W-1:0] fetch_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic              inst_is_c,
    output logic [31:0]       inst_pc
);

    localparam logic [31:0] RESET_FETCH_PC = RESET_PC & ~32'h3;
    localparam logic [31:0] RESET_INST_PC  = RESET_PC & ~32'h1;

    fetch_state_e    state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     inst_pc_q, inst_pc_d;
    logic            skip_low_q, skip_low_d;

    logic [HW_W-1:0] hw0, hw1;
    logic [1:0]      count;
    logic            head_is_c;
    logic            complete;
    logic            pop;
    logic            push;
    logic            req_fire;

    assign head_is_c = hw_is_c(hw0);
    assign complete  = ((count >= 2'd1) && head_is_c) || (count >= 2'd2);
    assign inst_valid = complete && !redirect_valid;
    assign inst_is_c  = complete && head_is_c;
    assign inst_data  = head_is_c ? {{HW_W{1'b0}}, hw0} : {hw1, hw0};
    assign inst_pc    = inst_pc_q;

    // Only request when a full word is guaranteed to fit behind what is left.
    assign fetch_req_valid = (state_q == REQ) && (count <= 2'd1) && !redirect_valid;
    assign fetch_req_addr  = fetch_pc_q;
    assign req_fire        = fetch_req_valid && fetch_req_ready;

    assign pop  = inst_valid && inst_ready;
    assign push = (state_q == WAIT) && fetch_rsp_valid && !redirect_valid;

    instr_hw_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .pop_i       (pop),
        .pop_two_i   (!head_is_c),
        .push_i      (push),
        .push_one_i  (skip_low_q),
        .push_data_i (fetch_rsp_data),
        .hw0_o       (hw0),
        .hw1_o       (hw1),
        .count_o     (count)
    );

    // Next state for the fetch FSM and the PC / skip registers.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inst_pc_d  = inst_pc_q;
        skip_low_d = skip_low_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~32'h3;
            inst_pc_d  = redirect_pc & ~32'h1;
            skip_low_d = redirect_pc[1];
            // An outstanding response must be thrown away; if it is arriving
            // right now it is already consumed, so waiting for it would hang.
            if (state_q != REQ) begin
                state_d = fetch_rsp_valid ? REQ : DROP;
            end
        end else begin
            case (state_q)
                REQ: begin
                    if (req_fire) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = WAIT;
                    end
                end
                WAIT: begin
                    if (fetch_rsp_valid) begin
                        skip_low_d = 1'b0;
                        state_d    = REQ;
                    end
                end
                DROP: begin
                    if (fetch_rsp_valid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
            if (pop) begin
                inst_pc_d = inst_pc_q + (head_is_c ? 32'd2 : 32'd4);
            end
        end
    end

    // FSM state and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_FETCH_PC;
            inst_pc_q  <= RESET_INST_PC;
            skip_low_q <= RESET_PC[1];
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inst_pc_q  <= inst_pc_d;
            skip_low_q <= skip_low_d;
        end
    end

endmodule
